operand_enable_ctrl: RTL and testbench
======================================

Name: operand_enable_ctrl

Overview:
- Control end of the operand gating path: generates the `en` strobe that the operand gating stage consumes.
- Accepts an operand pair on a valid/ready handshake and holds it in registers.
- Drives `en` high for exactly ALU_LAT cycles so the gated operands reach the ALU, then captures the ALU result.
- Presents the result downstream on a valid/ready handshake. Sits between the operand source and the gating stage/ALU.

Parameters:
- W, 4, operand and result width in bits.
- ALU_LAT, 1, cycles `en` stays high before the result is sampled; legal range 1..15.
- CW, 4, width of the internal latency counter; must satisfy 2^CW > ALU_LAT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- en  output  1  gate enable to the operand gating stage.
- a_q  output  W  registered operand A, fed to the gating stage A input.
- b_q  output  W  registered operand B, fed to the gating stage B input.
- alu_y  input  W  ALU result, computed from the gated operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  captured result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; en, out_valid, a_q, b_q, out_data and the counter all 0.
  - in_ready=0 while rst=1.
  - Takes effect immediately, including mid-ISSUE or mid-DONE. An in-flight op is discarded and `en` drops at once.
- FSM has three states: IDLE, ISSUE and DONE.
- IDLE:
  - in_ready=1 (combinational from state).
  - On in_valid&in_ready: a_q<=in_a, b_q<=in_b, en<=1, cnt<=0, go to ISSUE.
  - in_a/in_b are ignored when in_valid=0.
- ISSUE:
  - in_ready=0, en=1.
  - Each cycle cnt<=cnt+1.
  - On the cycle where cnt==ALU_LAT-1: out_data<=alu_y, en<=0, out_valid<=1, go to DONE.
  - `en` is high for exactly ALU_LAT consecutive cycles.
- DONE:
  - out_valid=1; out_data and a_q/b_q are held stable; in_ready=0.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - out_ready while out_valid=0 has no effect.
- Latency and throughput:
  - Accept edge to out_valid rising = ALU_LAT+1 cycles.
  - With out_ready tied high, one op completes every ALU_LAT+2 cycles. No overlap: one op in flight at a time.
- a_q/b_q are not cleared when `en` drops. The gating stage zeroes the ALU inputs via en=0.
- Backpressure: out_valid stays high indefinitely until out_ready. Upstream stalls (in_ready=0) for the whole period.
- Simultaneous events: out_ready and in_valid in the same DONE cycle means the result handshake completes, but the new operand is NOT accepted that cycle. It is accepted on the next cycle, in IDLE.
- Counter rolls over only through the reset to 0 on each new accept. No wrap occurs within a legal ALU_LAT.

Optional Feature:
- Macro OP_COUNT_EN.
- Defined:
  - Adds output op_count [7:0], reset 0.
  - Increments by 1 on every out_valid&out_ready handshake; wraps 255->0.
  - Cleared asynchronously by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- All cases: W=4; ALU model alu_y=(a_q&{4{en}})+(b_q&{4{en}}) mod 16.
- Reset: hold rst=1 for 3 cycles -> en=0, out_valid=0, in_ready=0, a_q=b_q=out_data=0000. Release -> in_ready=1 next cycle.
- Single op, ALU_LAT=1, out_ready=1: in_a=0011, in_b=1110 -> en high exactly 1 cycle, out_valid 2 cycles after accept, out_data=0001, back to IDLE with in_ready=1.
- Latency, ALU_LAT=3: in_a=1010, in_b=0100 -> en high 3 consecutive cycles, in_ready=0 throughout, out_data=1110 at cycle 4 after accept.
- Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid held with new operands -> out_valid and out_data=1110 stable, in_ready=0. Then out_ready=1 -> handshake, new op accepted on the following IDLE cycle.
- Reset mid-ISSUE (ALU_LAT=3): assert rst in the 2nd en cycle -> en=0 and state IDLE immediately, no out_valid pulse ever. With OP_COUNT_EN: op_count=0 after reset, =2 after two completed ops, wraps to 0 after 256 ops.

Source files
------------

// File: rtl/operand_enable_ctrl.sv
// Purpose : control end of the operand gating path. It accepts one operand pair,
//           holds it on a_q/b_q, raises en for ALU_LAT cycles, captures alu_y and
//           presents it on a valid/ready output.
// Latency : accept cycle to out_valid is ALU_LAT+1 cycles. With out_ready high,
//           one op completes every ALU_LAT+2 cycles, and only one op is in flight.
// Backpressure: out_valid holds until out_ready; in_ready stays low from accept
//           until the result handshake completes.
// Ports   : clk/rst (async, active-high); in_valid/in_ready/in_a/in_b upstream;
//           en/a_q/b_q to the gating stage; alu_y from the ALU;
//           out_valid/out_ready/out_data downstream.
// Option  : define OP_COUNT_EN to add op_count[7:0], which counts completed
//           result handshakes and wraps 255->0.
module operand_enable_ctrl #(
  parameter int W       = 4,
  parameter int ALU_LAT = 1,
  parameter int CW      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         en,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q,
  input  logic [W-1:0] alu_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef OP_COUNT_EN
  ,
  output logic [7:0]   op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(ALU_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          issue_last;

  assign accept     = in_valid & in_ready;
  assign issue_last = (state == ISSUE) && (cnt == LAST_CNT);

  // State register. Reset returns to IDLE at once, which drops en and
  // out_valid in the same instant because both are decoded from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. In DONE a concurrent in_valid is ignored, so a new
  // operand is taken only on the following IDLE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)           state_nxt = ISSUE;
      ISSUE:   if (cnt == LAST_CNT)  state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Output decode. en covers the ISSUE cycles exactly, which gives ALU_LAT
  // cycles. in_ready is masked by rst so upstream never sees it during reset.
  always_comb begin
    in_ready  = 1'b0;
    en        = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = ~rst;
      ISSUE:   en        = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand and result registers. a_q/b_q are left alone when en falls; the
  // gating stage zeroes the ALU inputs itself. alu_y is sampled in the last
  // en cycle, while the gated operands are still applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      out_data <= '0;
      cnt      <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= cnt + CW'(1);
      if (issue_last) begin
        out_data <= alu_y;
      end
    end
  end

`ifdef OP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid & out_ready) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_enable_ctrl.sv
// Bench for operand_enable_ctrl: two instances (ALU_LAT=1 and ALU_LAT=3) with a
// behavioural ALU, a per-instance transaction model and a directed-then-random
// stimulus sequence.
module tb_operand_enable_ctrl;
  localparam int W = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid [2];
  logic         in_ready [2];
  logic [W-1:0] in_a     [2];
  logic [W-1:0] in_b     [2];
  logic         en       [2];
  logic [W-1:0] a_q      [2];
  logic [W-1:0] b_q      [2];
  logic [W-1:0] alu_y    [2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic [W-1:0] out_data [2];
`ifdef OP_COUNT_EN
  logic [7:0]   op_count [2];
`endif

  // ALU environment: operands gated by en, then summed mod 16.
  assign alu_y[0] = (a_q[0] & {W{en[0]}}) + (b_q[0] & {W{en[0]}});
  assign alu_y[1] = (a_q[1] & {W{en[1]}}) + (b_q[1] & {W{en[1]}});

  operand_enable_ctrl #(.W(W), .ALU_LAT(LAT0), .CW(4)) u_lat1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .en(en[0]), .a_q(a_q[0]), .b_q(b_q[0]), .alu_y(alu_y[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
`ifdef OP_COUNT_EN
    , .op_count(op_count[0])
`endif
  );

  operand_enable_ctrl #(.W(W), .ALU_LAT(LAT1), .CW(4)) u_lat3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .en(en[1]), .a_q(a_q[1]), .b_q(b_q[1]), .alu_y(alu_y[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
`ifdef OP_COUNT_EN
    , .op_count(op_count[1])
`endif
  );

  // Reference model. age counts clock edges since the accept edge (0 = idle):
  // en is expected for ages 1..LAT, and the result is pending from age LAT+1.
  int           lat [2];
  int           age [2];
  logic [W-1:0] ea  [2];
  logic [W-1:0] eb  [2];
  logic [W-1:0] ed  [2];
  int           ecnt[2];
  int           vectors = 0;
  int           fails   = 0;

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      age[i]  = 0;
      ea[i]   = '0;
      eb[i]   = '0;
      ed[i]   = '0;
      ecnt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (age[i] == 0) begin
        if (in_valid[i]) begin
          ea[i]  = in_a[i];
          eb[i]  = in_b[i];
          age[i] = 1;
        end
      end else if (age[i] < lat[i]) begin
        age[i]++;
      end else if (age[i] == lat[i]) begin
        ed[i]  = W'((int'(ea[i]) + int'(eb[i])) % 16);
        age[i]++;
      end else if (out_ready[i]) begin
        age[i]  = 0;
        ecnt[i] = (ecnt[i] + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("in_ready",  i, {7'd0, in_ready[i]},  {7'd0, (age[i] == 0) && !rst});
      chk("en",        i, {7'd0, en[i]},        {7'd0, (age[i] >= 1) && (age[i] <= lat[i])});
      chk("out_valid", i, {7'd0, out_valid[i]}, {7'd0, age[i] > lat[i]});
      chk("a_q",       i, {4'd0, a_q[i]},       {4'd0, ea[i]});
      chk("b_q",       i, {4'd0, b_q[i]},       {4'd0, eb[i]});
      chk("out_data",  i, {4'd0, out_data[i]},  {4'd0, ed[i]});
`ifdef OP_COUNT_EN
      chk("op_count",  i, op_count[i],          8'(ecnt[i]));
`endif
    end
  endtask

  // One clock: model follows the DUT edge, and outputs are checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    lat[0] = LAT0;
    lat[1] = LAT1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
      out_ready[i] = 1'b0;
    end
    model_reset();

    // Reset held for three cycles, then released.
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Single op at ALU_LAT=1: 0011 + 1110 = 0001.
    in_valid[0] = 1'b1; in_a[0] = 4'b0011; in_b[0] = 4'b1110; out_ready[0] = 1'b1;
    cycle();
    in_valid[0] = 1'b0;
    cycle();
    chk("lat1_result", 0, {4'd0, out_data[0]}, 8'h01);
    cycle();
    chk("lat1_back_idle", 0, {7'd0, in_ready[0]}, 8'h01);

    // ALU_LAT=3 op 1010 + 0100 = 1110, held under backpressure while new
    // operands wait on in_valid.
    in_valid[1] = 1'b1; in_a[1] = 4'b1010; in_b[1] = 4'b0100; out_ready[1] = 1'b0;
    cycle();
    in_a[1] = 4'b0101; in_b[1] = 4'b1001;
    repeat (3) cycle();
    repeat (5) cycle();
    chk("lat3_held_result", 1, {4'd0, out_data[1]}, 8'h0e);
    out_ready[1] = 1'b1;
    cycle();
    cycle();
    chk("lat3_next_accept", 1, {4'd0, a_q[1]}, 8'h05);
    in_valid[1] = 1'b0;
    repeat (5) cycle();

    // Reset asserted during the second en cycle of an ALU_LAT=3 op.
    in_valid[1] = 1'b1; in_a[1] = 4'b0111; in_b[1] = 4'b0111;
    cycle();
    in_valid[1] = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_issue_en", 1, {7'd0, en[1]}, 8'h00);
    check_all();
    cycle();
    rst = 1'b0;
    repeat (6) cycle();

    // Randomised traffic on both instances.
    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = 1'($urandom_range(0, 1));
        in_a[i]      = W'($urandom);
        in_b[i]      = W'($urandom);
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    // Back-to-back streaming, long enough for the op counter to wrap.
    repeat (800) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = 1'b1;
        in_a[i]      = W'($urandom);
        in_b[i]      = W'($urandom);
        out_ready[i] = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
